// File: rtl/scroll_shift_reg.sv
// scroll_shift_reg
//   N-bit register with single-cycle parallel load, shift and rotate
//   operations, plus an optional auto-scroll engine that rotates the
//   register by one position every PERIOD cycles while enabled.
//
//   Build option: define SCROLL_SHIFT_AUTO_EN to include the auto-scroll
//   engine (prescaler, POS counter, wrap pulse). Without it, scroll and DIR
//   are ignored and POS / wrap read as zero.
//
//   Ports
//     clk     in   1   clock, rising edge
//     CLR     in   1   asynchronous active-high reset
//     D       in   N   parallel load data
//     SEL     in   3   0 hold, 1 load, 2 shl, 3 shr, 4 rotl, 5 rotr, 6/7 hold
//     AMT     in   AW  manual shift/rotate distance
//     FILL    in   1   bit shifted into vacated positions
//     scroll  in   1   auto-scroll enable (level)
//     DIR     in   1   auto-scroll direction: 0 rotate left, 1 rotate right
//     Q       out  N   register contents
//     POS     out  AW  auto-scroll step count modulo N
//     wrap    out  1   one-cycle pulse after a full auto-scroll revolution
module scroll_shift_reg #(
   parameter int unsigned   N         = 8,
   parameter int unsigned   PERIOD    = 4,
   parameter logic [N-1:0]  RESET_VAL = {{(N-1){1'b0}}, 1'b1},
   localparam int unsigned  AW        = $clog2(N)
) (
   input  logic          clk,
   input  logic          CLR,
   input  logic [N-1:0]  D,
   input  logic [2:0]    SEL,
   input  logic [AW-1:0] AMT,
   input  logic          FILL,
   input  logic          scroll,
   input  logic          DIR,
   output logic [N-1:0]  Q,
   output logic [AW-1:0] POS,
   output logic          wrap
);

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROTL = 3'd4,
      OP_ROTR = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } op_t;

   op_t            op;
   logic           manual;
   logic [N-1:0]   ones;
   logic [2*N-1:0] dbl_l;
   logic [2*N-1:0] dbl_r;
   logic [N-1:0]   q_man;
   logic [N-1:0]   q_next;

   assign op     = op_t'(SEL);
   assign manual = (op == OP_LOAD) || (op == OP_SHL) || (op == OP_SHR) ||
                   (op == OP_ROTL) || (op == OP_ROTR);

   // Manual operation datapath. Rotates use a doubled copy of Q so that
   // AMT=0 naturally yields Q without a special case.
   always_comb begin
      ones  = '1;
      dbl_l = {Q, Q} << AMT;
      dbl_r = {Q, Q} >> AMT;
      q_man = Q;
      case (op)
         OP_LOAD: q_man = D;
         OP_SHL:  q_man = (Q << AMT) | ({N{FILL}} & ~(ones << AMT));
         OP_SHR:  q_man = (Q >> AMT) | ({N{FILL}} & ~(ones >> AMT));
         OP_ROTL: q_man = dbl_l[2*N-1:N];
         OP_ROTR: q_man = dbl_r[N-1:0];
         default: q_man = Q;
      endcase
   end

`ifdef SCROLL_SHIFT_AUTO_EN
   localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [PW-1:0] presc;
   logic [AW-1:0] pos_r;
   logic          wrap_r;
   logic          tick;
   logic          auto_step;
   logic          last_pos;
   logic [N-1:0]  q_rot1;

   assign tick      = scroll && (presc == PW'(PERIOD - 1));
   // A manual operation in a tick cycle wins; the auto step is dropped.
   assign auto_step = tick && !manual;
   assign last_pos  = (pos_r == AW'(N - 1));
   assign q_rot1    = DIR ? {Q[0], Q[N-1:1]} : {Q[N-2:0], Q[N-1]};

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         presc <= '0;
      end else if ((op == OP_LOAD) || !scroll || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         pos_r  <= '0;
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= auto_step && last_pos;
         if (op == OP_LOAD) begin
            pos_r <= '0;
         end else if (auto_step) begin
            pos_r <= last_pos ? '0 : pos_r + 1'b1;
         end
      end
   end

   assign POS  = pos_r;
   assign wrap = wrap_r;

   always_comb begin
      q_next = Q;
      if (manual) begin
         q_next = q_man;
      end else if (auto_step) begin
         q_next = q_rot1;
      end
   end
`else
   logic unused_auto;

   assign unused_auto = scroll ^ DIR;
   assign POS         = '0;
   assign wrap        = 1'b0;

   always_comb begin
      q_next = Q;
      if (manual) begin
         q_next = q_man;
      end
   end
`endif

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         Q <= RESET_VAL;
      end else begin
         Q <= q_next;
      end
   end

endmodule
